// File: rtl/piano_sequencer_if.sv
// CPU-side command/status bus of the piano sequencer.
//
// Handshake: iDoPianoWrite is a single-cycle valid strobe qualifying
// iPianoDataToWrite. There is no ready; the write is always taken on the
// strobe edge. It either executes (STOP_ALL), queues, or is dropped.
// A dropped note is reported through the sticky oOverflow flag.
// oFifoFull lets the CPU avoid drops in the first place.
interface piano_sequencer_if;
    logic        iDoPianoWrite;
    logic        iDoPianoStatusClear;
    logic [31:0] iPianoDataToWrite;
    logic        oFifoFull;
    logic        oFifoEmpty;
    logic        oOverflow;

    modport master (
        output iDoPianoWrite, iDoPianoStatusClear, iPianoDataToWrite,
        input  oFifoFull, oFifoEmpty, oOverflow
    );

    modport slave (
        input  iDoPianoWrite, iDoPianoStatusClear, iPianoDataToWrite,
        output oFifoFull, oFifoEmpty, oOverflow
    );
endinterface

// File: rtl/piano_sequencer.sv
// Multi-channel square-wave tone sequencer.
// Note commands are queued in a FIFO and dispatched in order to idle channels.
// Each channel toggles its wave every half-period cycles for a number of beat ticks.
// The buzzer output is the OR of all channel waves.
module piano_sequencer #(
    parameter int CHANNELS   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TICK_DIV   = 12500000,
    parameter int PERIOD_W   = 16
) (
    input  logic                iCpuClock,
    input  logic                iCpuReset,
    piano_sequencer_if.slave    bus,
    output logic                oFpgaSpeaker,
    output logic [CHANNELS-1:0] oChannelWave,
    output logic [CHANNELS-1:0] oChannelBusy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TICK_DIV);
    // Queued entry: channel(2), duration(4), rest flag(1), half-period.
    localparam int EW = 7 + PERIOD_W;
    localparam logic [1:0]    OP_STOP   = 2'b10;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    // Write decode
    logic [1:0]    wrOp;
    logic          isStop;
    logic          isNote;
    logic [EW-1:0] wrEntry;
    logic          unusedData;

    assign wrOp    = bus.iPianoDataToWrite[25:24];
    assign isStop  = bus.iDoPianoWrite && (wrOp == OP_STOP);
    // PLAY (00) and REST (01) are queued; reserved (11) falls through silently.
    assign isNote  = bus.iDoPianoWrite && !wrOp[1];
    assign wrEntry = {bus.iPianoDataToWrite[31:26], bus.iPianoDataToWrite[24],
                      bus.iPianoDataToWrite[PERIOD_W-1:0]};
    // Bits between the op field and the half-period field carry no meaning.
    assign unusedData = ^(bus.iPianoDataToWrite[23:0] >> PERIOD_W);

    // FIFO state
    logic [EW-1:0] fifoMem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count, countNext;
    logic          fifoFull, fifoEmpty, overflow;

    // Channel state
    logic [CHANNELS-1:0] busyReg, waveReg, restReg;
    logic [3:0]          remaining [CHANNELS];
    logic [PERIOD_W-1:0] periodReg [CHANNELS];
    logic [PERIOD_W-1:0] phase     [CHANNELS];

    // Beat tick
    logic [TW-1:0] tickCnt;
    logic          tick;
    assign tick = (tickCnt == TICK_LAST);

    // Head-of-queue fields
    logic [EW-1:0]       head;
    logic [1:0]          headCh;
    logic [3:0]          headDur;
    logic                headRest;
    logic [PERIOD_W-1:0] headPeriod;
    logic                headValid, headBusy;
    logic                pop, dispatch, push, dropped;

    assign head       = fifoMem[rdPtr];
    assign headCh     = head[EW-1 -: 2];
    assign headDur    = head[EW-3 -: 4];
    assign headRest   = head[PERIOD_W];
    assign headPeriod = head[PERIOD_W-1:0];
    assign headValid  = int'(headCh) < CHANNELS;

    // Busy state of the head's target channel (0 when the channel does not exist).
    always_comb begin
        headBusy = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (headCh == 2'(c)) headBusy = busyReg[c];
        end
    end

    // Head-of-line blocking: the head leaves only when its channel is idle.
    // Invalid channels and zero-duration notes are discarded with one pop.
    assign pop      = !fifoEmpty && !isStop && (!headValid || headDur == 4'd0 || !headBusy);
    assign dispatch = pop && headValid && (headDur != 4'd0);
    // A full FIFO still accepts a note when the head pops on the same edge.
    assign push     = isNote && (!fifoFull || pop);
    assign dropped  = isNote && fifoFull && !pop;

    // Next occupancy; STOP_ALL empties the queue.
    always_comb begin
        countNext = count;
        if (isStop) countNext = '0;
        else        countNext = count + CW'(push) - CW'(pop);
    end

    // FIFO storage (contents need no reset; pointers/count define validity)
    always_ff @(posedge iCpuClock) begin
        if (push) fifoMem[wrPtr] <= wrEntry;
    end

    // FIFO pointers, registered status flags and the sticky overflow flag
    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            fifoFull  <= 1'b0;
            fifoEmpty <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            if (isStop) begin
                wrPtr <= '0;
                rdPtr <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + AW'(1);
                if (pop)  rdPtr <= rdPtr + AW'(1);
            end
            count     <= countNext;
            fifoFull  <= (countNext == DEPTH_C);
            fifoEmpty <= (countNext == '0);
            // A new overflow wins over a coincident clear.
            if (dropped)                      overflow <= 1'b1;
            else if (bus.iDoPianoStatusClear) overflow <= 1'b0;
        end
    end

    // Free-running beat counter; STOP_ALL restarts it.
    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset)           tickCnt <= '0;
        else if (isStop || tick) tickCnt <= '0;
        else                     tickCnt <= tickCnt + TW'(1);
    end

    // Per-channel note load, tone generation and beat countdown
    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            busyReg <= '0;
            waveReg <= '0;
            restReg <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                remaining[c] <= '0;
                periodReg[c] <= '0;
                phase[c]     <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (isStop) begin
                    busyReg[c]   <= 1'b0;
                    waveReg[c]   <= 1'b0;
                    restReg[c]   <= 1'b0;
                    remaining[c] <= '0;
                    periodReg[c] <= '0;
                    phase[c]     <= '0;
                end else if (dispatch && headCh == 2'(c)) begin
                    busyReg[c]   <= 1'b1;
                    waveReg[c]   <= 1'b0;
                    restReg[c]   <= headRest;
                    remaining[c] <= headDur;
                    periodReg[c] <= headPeriod;
                    phase[c]     <= '0;
                end else if (busyReg[c]) begin
                    if (tick && remaining[c] == 4'd1) begin
                        // Last beat ends on this tick edge; silence at once.
                        busyReg[c]   <= 1'b0;
                        waveReg[c]   <= 1'b0;
                        remaining[c] <= '0;
                        phase[c]     <= '0;
                    end else begin
                        if (tick) remaining[c] <= remaining[c] - 4'd1;
                        // Half-period 0 is a silent but busy note.
                        if (!restReg[c] && periodReg[c] != '0) begin
                            if (phase[c] == periodReg[c] - PERIOD_W'(1)) begin
                                phase[c]   <= '0;
                                waveReg[c] <= ~waveReg[c];
                            end else begin
                                phase[c] <= phase[c] + PERIOD_W'(1);
                            end
                        end
                    end
                end
            end
        end
    end

    assign oChannelBusy   = busyReg;
    assign oChannelWave   = waveReg;
    assign oFpgaSpeaker   = |waveReg;
    assign bus.oFifoFull  = fifoFull;
    assign bus.oFifoEmpty = fifoEmpty;
    assign bus.oOverflow  = overflow;
endmodule

// File: tb/tb_piano_sequencer.sv
// Directed bench for piano_sequencer with TICK_DIV=10 and FIFO_DEPTH=4.
// Each scenario starts with STOP_ALL so that beat ticks fall on known edges.
// "rel" counts rising edges since that STOP_ALL write edge, so ticks land on rel 10, 20, 30, ...
module tb_piano_sequencer;
    localparam int CHANNELS   = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int TICK_DIV   = 10;
    localparam int PERIOD_W   = 16;
    localparam int OP_PLAY = 0;
    localparam int OP_REST = 1;
    localparam int OP_STOP = 2;
    localparam int OP_RSVD = 3;

    logic                iCpuClock = 1'b0;
    logic                iCpuReset;
    logic                oFpgaSpeaker;
    logic [CHANNELS-1:0] oChannelWave;
    logic [CHANNELS-1:0] oChannelBusy;

    piano_sequencer_if bus();

    piano_sequencer #(
        .CHANNELS  (CHANNELS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TICK_DIV  (TICK_DIV),
        .PERIOD_W  (PERIOD_W)
    ) dut (
        .iCpuClock   (iCpuClock),
        .iCpuReset   (iCpuReset),
        .bus         (bus),
        .oFpgaSpeaker(oFpgaSpeaker),
        .oChannelWave(oChannelWave),
        .oChannelBusy(oChannelBusy)
    );

    // Clock: rising edges at 5, 15, 25, ...
    always #5 iCpuClock = ~iCpuClock;

    int testsRun    = 0;
    int testsFailed = 0;
    int rel         = 0;
    logic waveSeen;
    logic busyDropped;

    function automatic logic [31:0] cmd(input int ch, input int dur, input int op, input int hp);
        return {2'(ch), 4'(dur), 2'(op), 8'h00, 16'(hp)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge iCpuClock);
        #1;
        rel++;
    endtask

    task automatic stepTo(input int target);
        while (rel < target) step();
    endtask

    // One-cycle write strobe; returns 1 ns after the write edge.
    task automatic writeCmd(input logic [31:0] data);
        bus.iPianoDataToWrite = data;
        bus.iDoPianoWrite     = 1'b1;
        step();
        bus.iDoPianoWrite     = 1'b0;
    endtask

    task automatic stopAll();
        writeCmd(cmd(0, 0, OP_STOP, 0));
        rel = 0;
    endtask

    initial begin
        bus.iDoPianoWrite       = 1'b0;
        bus.iDoPianoStatusClear = 1'b0;
        bus.iPianoDataToWrite   = '0;
        iCpuReset               = 1'b1;

        // Reset values
        #12;
        check("rst_speaker", 32'(oFpgaSpeaker), 0);
        check("rst_wave", 32'(oChannelWave), 0);
        check("rst_busy", 32'(oChannelBusy), 0);
        check("rst_full", 32'(bus.oFifoFull), 0);
        check("rst_empty", 32'(bus.oFifoEmpty), 1);
        check("rst_overflow", 32'(bus.oOverflow), 0);
        #10;
        iCpuReset = 1'b0;
        step();

        // Single PLAY ch0 dur 3 half-period 2
        stopAll();
        writeCmd(cmd(0, 3, OP_PLAY, 2));                      // rel 1
        check("s1_empty_after_write", 32'(bus.oFifoEmpty), 0);
        check("s1_busy_not_yet", 32'(oChannelBusy[0]), 0);
        step();                                              // rel 2: pop
        check("s1_busy_at_pop", 32'(oChannelBusy[0]), 1);
        check("s1_wave_at_pop", 32'(oChannelWave[0]), 0);
        check("s1_empty_after_pop", 32'(bus.oFifoEmpty), 1);
        stepTo(3);
        check("s1_wave_rel3", 32'(oChannelWave[0]), 0);
        stepTo(4);
        check("s1_wave_rel4", 32'(oChannelWave[0]), 1);
        stepTo(5);
        check("s1_wave_rel5", 32'(oChannelWave[0]), 1);
        stepTo(6);
        check("s1_wave_rel6", 32'(oChannelWave[0]), 0);
        stepTo(29);
        check("s1_busy_before_tick3", 32'(oChannelBusy[0]), 1);
        check("s1_speaker_rel29", 32'(oFpgaSpeaker), 1);
        stepTo(30);
        check("s1_busy_at_tick3", 32'(oChannelBusy[0]), 0);
        check("s1_wave_at_tick3", 32'(oChannelWave[0]), 0);
        stepTo(34);
        check("s1_speaker_after", 32'(oFpgaSpeaker), 0);

        // Overflow: 5 writes to busy ch1 with a 4-entry FIFO
        stopAll();
        writeCmd(cmd(1, 3, OP_PLAY, 5));                      // rel 1
        step();                                              // rel 2: pop
        bus.iPianoDataToWrite = cmd(1, 1, OP_PLAY, 3);
        bus.iDoPianoWrite     = 1'b1;
        repeat (4) step();                                   // rel 3..6 pushed
        check("s2_full_after4", 32'(bus.oFifoFull), 1);
        check("s2_ovf_after4", 32'(bus.oOverflow), 0);
        step();                                              // rel 7 dropped
        bus.iDoPianoWrite = 1'b0;
        check("s2_full_after5", 32'(bus.oFifoFull), 1);
        check("s2_ovf_after5", 32'(bus.oOverflow), 1);
        check("s2_busy1", 32'(oChannelBusy[1]), 1);
        bus.iDoPianoStatusClear = 1'b1;
        step();                                              // rel 8
        bus.iDoPianoStatusClear = 1'b0;
        check("s2_ovf_cleared", 32'(bus.oOverflow), 0);
        stepTo(30);
        check("s2_busy_end_first", 32'(oChannelBusy[1]), 0);
        check("s2_full_at30", 32'(bus.oFifoFull), 1);
        stepTo(31);
        check("s2_busy_entry1", 32'(oChannelBusy[1]), 1);
        check("s2_full_after_pop", 32'(bus.oFifoFull), 0);
        stepTo(40);
        check("s2_gap_rel40", 32'(oChannelBusy[1]), 0);
        stepTo(41);
        check("s2_busy_entry2", 32'(oChannelBusy[1]), 1);
        stepTo(61);
        check("s2_busy_entry4", 32'(oChannelBusy[1]), 1);
        check("s2_empty_entry4", 32'(bus.oFifoEmpty), 1);
        stepTo(70);
        check("s2_busy_done", 32'(oChannelBusy[1]), 0);
        stepTo(72);
        check("s2_no_fifth_note", 32'(oChannelBusy[1]), 0);

        // Head-of-line blocking
        stopAll();
        writeCmd(cmd(0, 4, OP_PLAY, 3));                      // rel 1
        writeCmd(cmd(0, 1, OP_PLAY, 3));                      // rel 2 (first pops)
        writeCmd(cmd(2, 1, OP_PLAY, 3));                      // rel 3
        stepTo(20);
        check("s3_ch2_blocked", 32'(oChannelBusy), 32'b0001);
        check("s3_fifo_not_empty", 32'(bus.oFifoEmpty), 0);
        stepTo(40);
        check("s3_ch0_first_done", 32'(oChannelBusy), 32'b0000);
        stepTo(41);
        check("s3_ch0_second", 32'(oChannelBusy), 32'b0001);
        stepTo(42);
        check("s3_ch2_starts", 32'(oChannelBusy), 32'b0101);
        stepTo(50);
        check("s3_all_done", 32'(oChannelBusy), 32'b0000);

        // REST ch3 dur 2: busy, never any wave
        stopAll();
        writeCmd(cmd(3, 2, OP_REST, 2));                      // rel 1
        step();                                              // rel 2
        waveSeen    = 1'b0;
        busyDropped = 1'b0;
        while (rel < 20) begin
            waveSeen    = waveSeen | oChannelWave[3] | oFpgaSpeaker;
            busyDropped = busyDropped | ~oChannelBusy[3];
            step();
        end
        check("s4_rest_wave", 32'(waveSeen), 0);
        check("s4_rest_busy", 32'(busyDropped), 0);
        check("s4_rest_end", 32'(oChannelBusy[3]), 0);

        // PLAY with half-period 0 behaves like REST
        stopAll();
        writeCmd(cmd(3, 2, OP_PLAY, 0));
        step();
        waveSeen    = 1'b0;
        busyDropped = 1'b0;
        while (rel < 20) begin
            waveSeen    = waveSeen | oChannelWave[3] | oFpgaSpeaker;
            busyDropped = busyDropped | ~oChannelBusy[3];
            step();
        end
        check("s4_hp0_wave", 32'(waveSeen), 0);
        check("s4_hp0_busy", 32'(busyDropped), 0);
        check("s4_hp0_end", 32'(oChannelBusy[3]), 0);

        // Duration 0 is discarded; reserved op is ignored without overflow
        stopAll();
        writeCmd(cmd(0, 0, OP_PLAY, 2));                      // rel 1
        check("s5_dur0_queued", 32'(bus.oFifoEmpty), 0);
        step();                                              // rel 2: discarded
        check("s5_dur0_empty", 32'(bus.oFifoEmpty), 1);
        step();
        check("s5_dur0_no_busy", 32'(oChannelBusy), 0);
        writeCmd(cmd(0, 2, OP_RSVD, 2));
        check("s5_rsvd_empty", 32'(bus.oFifoEmpty), 1);
        check("s5_rsvd_no_ovf", 32'(bus.oOverflow), 0);
        step();
        check("s5_rsvd_no_busy", 32'(oChannelBusy), 0);

        // STOP_ALL mid-play with FIFO full
        stopAll();
        writeCmd(cmd(0, 5, OP_PLAY, 2));                      // rel 1
        step();                                              // rel 2: pop
        bus.iPianoDataToWrite = cmd(0, 1, OP_PLAY, 2);
        bus.iDoPianoWrite     = 1'b1;
        repeat (4) step();                                   // rel 3..6
        bus.iDoPianoWrite = 1'b0;
        check("s6_full", 32'(bus.oFifoFull), 1);
        stepTo(8);
        check("s6_speaker_on", 32'(oFpgaSpeaker), 1);
        writeCmd(cmd(0, 0, OP_STOP, 0));                      // rel 9
        check("s6_busy_cleared", 32'(oChannelBusy), 0);
        check("s6_speaker_off", 32'(oFpgaSpeaker), 0);
        check("s6_empty", 32'(bus.oFifoEmpty), 1);
        check("s6_not_full", 32'(bus.oFifoFull), 0);
        check("s6_no_overflow", 32'(bus.oOverflow), 0);
        step();
        check("s6_stays_idle", 32'(oChannelBusy), 0);

        // Asynchronous reset mid-note
        stopAll();
        writeCmd(cmd(1, 3, OP_PLAY, 1));                      // rel 1
        stepTo(5);
        check("s7_wave_before_rst", 32'(oChannelWave[1]), 1);
        check("s7_busy_before_rst", 32'(oChannelBusy[1]), 1);
        #3;
        iCpuReset = 1'b1;
        #1;
        check("s7_rst_busy", 32'(oChannelBusy), 0);
        check("s7_rst_wave", 32'(oChannelWave), 0);
        check("s7_rst_speaker", 32'(oFpgaSpeaker), 0);
        check("s7_rst_empty", 32'(bus.oFifoEmpty), 1);
        check("s7_rst_full", 32'(bus.oFifoFull), 0);
        #2;
        iCpuReset = 1'b0;
        step();
        stopAll();
        writeCmd(cmd(2, 1, OP_PLAY, 2));                      // rel 1
        step();                                              // rel 2
        check("s7_after_busy", 32'(oChannelBusy), 32'b0100);
        stepTo(4);
        check("s7_after_wave", 32'(oChannelWave), 32'b0100);
        stepTo(10);
        check("s7_after_done", 32'(oChannelBusy), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/piano_sequencer.md
# piano_sequencer

Parametrised multi-channel square-wave tone sequencer: the successor to the single-command piano driver on the memory-mapped IO bus. The CPU posts note commands into a command FIFO. A dispatcher issues them in order to `CHANNELS` independent tone channels, each of which plays a programmable half-period for a programmable number of beats. It drives the board buzzer with the OR of all active channels and exposes FIFO and overflow status to the CPU.

## Interface
Parameters:
- `CHANNELS`, 4: number of tone channels (1..4).
- `FIFO_DEPTH`, 8: command FIFO entries (power of 2, ≥2).
- `TICK_DIV`, 12500000: iCpuClock cycles per beat tick (≥2).
- `PERIOD_W`, 16: half-period field width (≤24).

Ports:
- `iCpuClock`  in  1  system clock; all logic rising-edge.
- `iCpuReset`  in  1  reset, asynchronous, active-high.
- `iDoPianoWrite`  in  1  write strobe from memorio (command write).
- `iDoPianoStatusClear`  in  1  clears sticky overflow flag.
- `iPianoDataToWrite`  in  32  command word.
- `oFpgaSpeaker`  out  1  mixed buzzer output.
- `oChannelWave`  out  CHANNELS  per-channel square wave.
- `oChannelBusy`  out  CHANNELS  channel playing or resting.
- `oFifoFull`, `oFifoEmpty`  out  1  FIFO status.
- `oOverflow`  out  1  sticky: a write was dropped.

## Operation
- Command word: [31:30] channel, [29:26] duration in beats, [25:24] op, [PERIOD_W-1:0] half-period in cycles. Other bits ignored.
- Ops: 00 PLAY, 01 REST (channel busy, wave low), 10 STOP_ALL, 11 reserved (dropped silently, no overflow).
- STOP_ALL bypasses the FIFO. On the write edge it empties the FIFO, clears all channels (busy=0, wave=0, counters=0) and resets the beat counter. It is accepted even when the FIFO is full.
- PLAY/REST writes push into the FIFO when not full. If full and no pop occurs that cycle, the write is dropped and `oOverflow` is set. If full with a simultaneous pop, the write is accepted.
- A channel field ≥ CHANNELS is dropped at dispatch, costing one pop cycle.
- Duration 0 is popped and discarded with no effect.
- Dispatcher: in-order, head-of-line blocking. The head pops only when its target channel is idle.
  - On pop: remaining ← duration, period register ← half-period, phase counter ← 0, wave ← 0.
  - Busy is set the same edge.
- Tone: while busy with PLAY and half-period ≠ 0, the phase counter increments each cycle. When it reaches half-period−1 it wraps to 0 and the wave toggles. Half-period 0 means silent but busy.
- Beat tick: a free-running counter 0..TICK_DIV−1. The tick pulses one cycle when the counter equals TICK_DIV−1.
  - Every tick, each busy channel decrements remaining.
  - Reaching 0 clears busy and forces the wave to 0 the same edge.
  - The first beat is partial; quantisation to tick boundaries is intended.
- `oFpgaSpeaker` = OR of `oChannelWave`.
- `iDoPianoStatusClear` clears `oOverflow`. If it coincides with a new overflow, the overflow wins.
- Priority on one edge: STOP_ALL > pop/push > status clear.

## Timing
- Reset values: all outputs 0 except `oFifoEmpty`=1. FIFO pointers, counters and channel state are all 0.
- Reset mid-note silences immediately (asynchronous).
- Write→FIFO: registered on the write edge. `oFifoEmpty` falls the next cycle.
- FIFO→channel: the earliest pop is the edge after the push edge, so the channel is busy 2 edges after the write when the channel is idle.
- The first wave toggle occurs half-period cycles after the pop edge.
- Busy duration: between d−1 and d beat ticks after the pop, ending on a tick edge.
- A channel freed on a tick edge can accept the next pop on the following edge. Back-to-back notes on one channel therefore have a 1-cycle gap.
- Full/empty flags are registered from the pointer/count. Count width is clog2(FIFO_DEPTH)+1, and pointers wrap modulo FIFO_DEPTH.

## Test plan
TICK_DIV=10, FIFO_DEPTH=4.
- Reset, then PLAY ch0 dur 3 half-period 2 → busy0 at write+2 edges. Wave period is 4 cycles. Busy clears on the 3rd tick after the pop; wave is 0 afterwards.
- 5 PLAY writes to ch1 (dur 1) in consecutive cycles with ch1 busy → 4 accepted, `oFifoFull`=1, `oOverflow`=1. Status clear → 0. Entries play sequentially, one per tick.
- PLAY ch0 dur 4, then PLAY ch0 dur 1, then PLAY ch2 dur 1 → the ch2 entry waits behind the ch0 entry (head-of-line blocking). ch2 starts only after ch0's first note ends.
- REST ch3 dur 2 → busy3=1 and wave3=0 throughout. Half-period 0 PLAY behaves the same.
- Mid-play STOP_ALL with FIFO full → next edge: all busy=0, speaker=0, `oFifoEmpty`=1. `oOverflow` is not set.
- Assert iCpuReset asynchronously mid-note (between clock edges) → all outputs return to reset values immediately. Subsequent PLAY works normally.
